// File: rtl/instr_encoder_loader.sv
// Packs decoded MIPS instruction fields into 32-bit words, rejects illegal encodings and
// streams legal words into instruction memory. Optional DELAY_SLOT_NOP_EN appends a nop after branches/jumps.
module instr_encoder_loader #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        fmt,
    input  logic [5:0]        opc,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        sa,
    input  logic [5:0]        fun,
    input  logic [15:0]       imm,
    input  logic [25:0]       iindex,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    input  logic              im_ack,
    output logic              busy,
    output logic              full,
    output logic [ADDR_W:0]   word_count,
    output logic              is_illegal,
    output logic              illegal_pulse
);

    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   CAPACITY = {1'b1, {ADDR_W{1'b0}}};

    localparam logic [1:0] FMT_I = 2'b00;
    localparam logic [1:0] FMT_J = 2'b01;
    localparam logic [1:0] FMT_R = 2'b10;

`ifdef DELAY_SLOT_NOP_EN
    typedef enum logic [2:0] {ST_IDLE, ST_ACCEPT, ST_WRITE, ST_FULL, ST_NOP_WRITE} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_ACCEPT, ST_WRITE, ST_FULL} state_t;
`endif

    state_t              state_reg;
    logic                stop_pending_reg;
    logic                im_we_reg;
    logic [ADDR_W-1:0]   im_addr_reg;
    logic [31:0]         im_wdata_reg;
    logic                full_reg;
    logic [ADDR_W:0]     word_count_reg;
    logic                is_illegal_reg;
    logic                illegal_pulse_reg;

    logic [31:0]         packed_word;
    logic                word_legal;
    logic [ADDR_W:0]     word_count_next;
    logic                mem_filled;
    logic                leave_after_write;

    // Field packing and legality for the decoder's accepted subset
    always_comb begin
        packed_word = 32'h0;
        word_legal  = 1'b0;
        case (fmt)
            FMT_I: begin
                packed_word = {opc, rs, rt, imm};
                casez (opc)
                    6'b001???, 6'b10?011, 6'b00010?: word_legal = 1'b1;
                    6'b000001: word_legal = (rt[4:1] == 4'b0000);
                    6'b00011?: word_legal = (rt == 5'b00000);
                    default:   word_legal = 1'b0;
                endcase
            end
            FMT_J: begin
                packed_word = {opc, iindex};
                word_legal  = (opc[5:1] == 5'b00001);
            end
            FMT_R: begin
                packed_word = {opc, rs, rt, rd, sa, fun};
                if (opc == 6'b000000) begin
                    casez (fun)
                        6'b100???, 6'b000010, 6'b10101?,
                        6'b001000, 6'b001010, 6'b001100: word_legal = 1'b1;
                        default: word_legal = 1'b0;
                    endcase
                end else if (opc == 6'b010000) begin
                    word_legal = (rs == 5'b00000) || (rs == 5'b00100) ||
                                 ((rs == 5'b10000) && (fun == 6'b011000));
                end
            end
            default: begin
                packed_word = 32'h0;
                word_legal  = 1'b0;
            end
        endcase
    end

`ifdef DELAY_SLOT_NOP_EN
    logic branch_reg;
    logic needs_delay_slot;

    always_comb begin
        needs_delay_slot = 1'b0;
        casez (opc)
            6'b0001??, 6'b000001, 6'b00001?: needs_delay_slot = 1'b1;
            6'b000000: needs_delay_slot = (fun == 6'b001000) || (fun == 6'b001001);
            default:   needs_delay_slot = 1'b0;
        endcase
    end
`endif

    assign word_count_next   = word_count_reg + (ADDR_W + 1)'(1);
    assign mem_filled        = (word_count_next == CAPACITY);
    assign leave_after_write = stop_pending_reg | stop;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= ST_IDLE;
            stop_pending_reg  <= 1'b0;
            im_we_reg         <= 1'b0;
            im_addr_reg       <= '0;
            im_wdata_reg      <= 32'h0;
            full_reg          <= 1'b0;
            word_count_reg    <= '0;
            is_illegal_reg    <= 1'b0;
            illegal_pulse_reg <= 1'b0;
`ifdef DELAY_SLOT_NOP_EN
            branch_reg        <= 1'b0;
`endif
        end else begin
            illegal_pulse_reg <= 1'b0;
            case (state_reg)
                ST_IDLE, ST_ACCEPT, ST_FULL: begin
                    if (start) begin
                        state_reg        <= ST_ACCEPT;
                        im_addr_reg      <= BASE;
                        word_count_reg   <= '0;
                        is_illegal_reg   <= 1'b0;
                        full_reg         <= 1'b0;
                        stop_pending_reg <= 1'b0;
                    end else if (stop && state_reg != ST_IDLE) begin
                        state_reg <= ST_IDLE;
                    end else if (in_valid && state_reg == ST_ACCEPT) begin
                        if (word_legal) begin
                            state_reg    <= ST_WRITE;
                            im_we_reg    <= 1'b1;
                            im_wdata_reg <= packed_word;
`ifdef DELAY_SLOT_NOP_EN
                            branch_reg   <= needs_delay_slot;
`endif
                        end else begin
                            illegal_pulse_reg <= 1'b1;
                            is_illegal_reg    <= 1'b1;
                        end
                    end
                end
`ifdef DELAY_SLOT_NOP_EN
                ST_WRITE, ST_NOP_WRITE: begin
`else
                ST_WRITE: begin
`endif
                    if (stop) begin
                        stop_pending_reg <= 1'b1;
                    end
                    if (im_ack) begin
                        im_addr_reg    <= im_addr_reg + ADDR_W'(1);
                        word_count_reg <= word_count_next;
                        im_we_reg      <= 1'b0;
                        if (mem_filled) begin
                            // A delay-slot nop that would not fit is dropped
                            full_reg         <= 1'b1;
                            stop_pending_reg <= 1'b0;
                            state_reg        <= leave_after_write ? ST_IDLE : ST_FULL;
`ifdef DELAY_SLOT_NOP_EN
                        end else if (branch_reg && state_reg == ST_WRITE) begin
                            state_reg    <= ST_NOP_WRITE;
                            im_we_reg    <= 1'b1;
                            im_wdata_reg <= 32'h0;
`endif
                        end else begin
                            stop_pending_reg <= 1'b0;
                            state_reg        <= leave_after_write ? ST_IDLE : ST_ACCEPT;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign in_ready      = (state_reg == ST_ACCEPT);
    assign busy          = (state_reg != ST_IDLE);
    assign im_we         = im_we_reg;
    assign im_addr       = im_addr_reg;
    assign im_wdata      = im_wdata_reg;
    assign full          = full_reg;
    assign word_count    = word_count_reg;
    assign is_illegal    = is_illegal_reg;
    assign illegal_pulse = illegal_pulse_reg;

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the instruction decode path: takes decoded instruction fields (format, opcode, register numbers, shift amount, function, immediate, jump index) and packs them into 32-bit MIPS words.
- Checks each word against the same legal-instruction subset the decoder accepts.
- Writes legal words sequentially into instruction memory through a write/ack handshake.
- Used by the bench and the boot loader to fill instruction memory before the CPU runs.

Parameters:
- ADDR_W, 8, instruction-memory word-address width; capacity is 2^ADDR_W words.
- BASE_ADDR, 0, first word address written after start; addresses wrap modulo 2^ADDR_W.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  opens a load session: address to BASE_ADDR, counters and sticky flags cleared.
- stop  in  1  closes the session; returns to IDLE once no write is pending.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  block can accept a bundle.
- fmt  in  2  00 I-type, 01 J-type, 10 R-type, 11 undefined.
- opc  in  6  opcode.
- rs, rt, rd, sa  in  5 each  register fields and shift amount.
- fun  in  6  function field.
- imm  in  16  immediate.
- iindex  in  26  jump index.
- im_we  out  1  memory write request.
- im_addr  out  ADDR_W  write word address.
- im_wdata  out  32  encoded word.
- im_ack  in  1  memory accepted the write.
- busy  out  1  state is not IDLE.
- full  out  1  2^ADDR_W words written this session.
- word_count  out  ADDR_W+1  words written this session.
- is_illegal  out  1  sticky: at least one bundle was rejected this session.
- illegal_pulse  out  1  one-cycle pulse per rejected bundle.

Behaviour:
- Reset: state IDLE. All outputs 0: in_ready, im_we, im_addr, im_wdata, busy, full, word_count, is_illegal, illegal_pulse.
- States: IDLE, ACCEPT, WRITE, FULL.
- IDLE:
  - in_ready=0.
  - start -> ACCEPT; im_addr=BASE_ADDR, word_count=0, is_illegal=0, full=0.
  - stop is ignored.
- ACCEPT: in_ready=1.
  - in_valid accepted and legal -> WRITE next cycle, im_we=1 with the packed word (1-cycle latency).
  - in_valid accepted and illegal -> no write; illegal_pulse=1 for 1 cycle; is_illegal set; stay in ACCEPT.
- Packing:
  - R: {opc, rs, rt, rd, sa, fun}.
  - I: {opc, rs, rt, imm}.
  - J: {opc, iindex}.
- Legality:
  - I-type requires opc 001???, 10?011 or 00010?. Also legal: opc 000001 with rt[4:1]=0000, and opc 00011? with rt=00000.
  - R-type requires opc 000000 with fun[5:3]=100, fun=000010, fun[5:1]=10101, or fun in {001000, 001010, 001100}.
  - R-type also allows opc 010000 with rs=00000 or rs=00100, or with rs=10000 and fun=011000.
  - J-type requires opc 00001?.
  - fmt=11 or any mismatch is illegal.
- WRITE:
  - im_we, im_addr and im_wdata are held stable until im_ack.
  - im_ack may arrive in the first cycle of im_we.
  - On ack: im_addr increments (wraps), word_count increments. If word_count reaches 2^ADDR_W -> FULL, otherwise -> ACCEPT. im_we drops the cycle after ack.
- FULL: in_ready=0, full=1. Incoming bundles are not accepted. stop -> IDLE.
- stop:
  - In ACCEPT or FULL: -> IDLE next cycle.
  - In WRITE: latched; the pending write completes, then -> IDLE.
  - stop and in_valid in the same ACCEPT cycle: stop wins, bundle not accepted.
- start outside IDLE:
  - In ACCEPT or FULL: restarts the session, same as from IDLE.
  - In WRITE: ignored.
- rst in any state, including mid-write: immediate return to reset values; the pending write is abandoned.
- Throughput: 1 word per 2 cycles with zero-wait ack.

Optional Feature:
- Macro: DELAY_SLOT_NOP_EN.
- With it defined:
  - Branch and jump words trigger an automatic delay-slot nop: opc 0001??, 000001, 00001?, or opc 000000 with fun 001000 or 001001.
  - After the word is acked, the block writes 32'h00000000 at the next address via a NOP_WRITE state before returning to ACCEPT.
  - in_ready=0 during NOP_WRITE. The nop counts in word_count.
  - If the branch filled memory, the nop is dropped and state goes to FULL.
- Without it: words are written exactly as supplied; no NOP_WRITE state exists.

Test Plan:
- rst, start, R addu (rs=1, rt=2, rd=3, sa=0, fun=100001), ack immediately -> im_we next cycle, im_addr=0, im_wdata=0x00221821, word_count=1.
- I addiu (opc=001001, rs=0, rt=5, imm=7), then J j (opc=000010, iindex=0x100) -> 0x24050007 at addr 0, 0x08000100 at addr 1.
- fmt=J with opc=001000 -> illegal_pulse for 1 cycle, is_illegal=1, no im_we, word_count unchanged; next legal word still goes to addr 0.
- im_ack held low 3 cycles during a write -> im_we, im_addr and im_wdata stable all 3 cycles; in_ready=0; single increment after ack.
- ADDR_W=2: write 4 legal words -> full=1, in_ready=0, word_count=4; stop -> IDLE; start -> word_count=0, im_addr=BASE_ADDR.
- DELAY_SLOT_NOP_EN: beq (opc=000100, rs=1, rt=2, imm=3) -> 0x10220003 at addr 0, then 0x00000000 at addr 1, word_count=2.
